gap_pool_unit: RTL and testbench
================================

# gap_pool_unit

Parametrised global pooling engine for the EPU tail, following the fixed 4x4 global-average-pool stage. Accepts a feature map as a stream of multi-lane beats over a valid/ready handshake and reduces each channel to one value, either a round-half-to-even average or a maximum. Results are emitted one channel at a time on a back-pressurable output port.

## Interface
- DATA_W, 8: unsigned sample width.
- CH, 4: channel count; also the number of results per frame.
- LANES, 4: samples per channel per beat; must be a power of two.
- LOG2_BEATS_MAX, 4: maximum log2 of beats per frame.
- Derived: SH_L = log2(LANES); ACC_W = DATA_W + SH_L + LOG2_BEATS_MAX.

- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  frame start pulse; sampled only in IDLE.
- cfg_mode  in  1  0 = average, 1 = max; latched on start.
- cfg_log2_beats  in  clog2(LOG2_BEATS_MAX+1)  beats per frame = 2^value; latched on start; values above LOG2_BEATS_MAX clamp to LOG2_BEATS_MAX.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  CH*LANES*DATA_W  channel c, lane l at bits [(c*LANES+l)*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  DATA_W  pooled value.
- out_ch  out  clog2(CH) (min 1)  channel index of out_data.
- out_last  out  1  high with the CH-1 result.
- busy  out  1  state != IDLE.

## Operation
- FSM states are IDLE, ACC and POP.
- IDLE: in_ready = 0, out_valid = 0. On start, latch cfg, clear all CH accumulators and the beat counter, then go to ACC.
- ACC: in_ready = 1. Each accepted beat updates every channel and increments the beat counter.
  - Average mode: acc[c] += sum of the LANES lanes.
  - Max mode: acc[c] = max(acc[c], max over lanes).
- ACC exit: when the accepted beat is beat 2^cfg-1, go to POP with the channel index set to 0. in_valid without a handshake changes nothing.
- POP: out_valid = 1 and out_ch = channel index.
  - On each handshake the index increments.
  - A handshake on index CH-1 returns the FSM to IDLE.
  - out_last = out_valid && (index == CH-1).
- Average result: s = SH_L + cfg_log2_beats, q = acc >> s, r = acc[s-1:0], half = 2^(s-1).
  - Round up when r > half, or when r == half and q[0] == 1.
  - When s == 0, out = acc.
  - The result always fits DATA_W with no saturation needed, since the maximum q is 2^DATA_W-1 and r = 0 at that point.
- Max result: out = acc[DATA_W-1:0].
- Accumulators never overflow, because ACC_W covers the worst-case sum.
- start outside IDLE is ignored, including start coinciding with the last ACC beat or the final POP handshake.
- start in IDLE together with in_valid: no beat is taken in that cycle, because in_ready is 0 in IDLE.

## Timing
- Reset (rst_n low at an edge), from any state:
  - state goes to IDLE;
  - accumulators, beat counter, channel index and latched cfg are cleared;
  - in_ready = 0, out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, busy = 0.
- start accepted at edge t: in_ready = 1 from cycle t+1.
- Last beat accepted at edge t: out_valid = 1 with out_ch = 0 from cycle t+1, so there is one cycle of latency.
- Sustained output throughput is one result per cycle while out_ready = 1. A frame drains in CH cycles minimum.
- While out_valid && !out_ready, out_data, out_ch and out_last stay stable.
- The final POP handshake at edge t puts the FSM in IDLE at t+1. A start at t+1 is accepted, giving a minimum of one idle cycle between frames.
- Output decode (shift, round, select) is combinational from registered acc, index and cfg. in_ready and out_valid are decoded from the state register only.

## Test plan
- Average, cfg = 0, one beat. Lanes: ch0 = 1,2,3,4; ch1 = 3,3,3,5; ch2 = 255 x4; ch3 = 0,0,0,3. Required: out_data 2, 4, 255, 1 on out_ch 0..3, with out_last only on ch3. This covers ties to even in both directions, the maximum value and a plain round-up.
- Average, cfg = 2 (4 beats, divisor 16). ch0 = 1 in every lane of every beat gives 1. ch1 = 8 in lane 0 of beat 0 only gives 0 (0.5 rounds to even). ch2 totals 24 gives 2 (1.5 rounds to even).
- Max, cfg = 1. ch0 beats (5,9,2,7) then (1,1,12,0) give 12. ch1 all zero gives 0.
- in_valid toggled 1,0,1,0,1,1 with cfg = 2: only the 4 handshakes count, and out_valid rises the cycle after the 4th.
- out_ready held low 3 cycles at out_ch = 1: out_data/out_ch/out_last stay stable, then the frame completes, with start ignored throughout POP.
- rst_n low for one edge after 2 of 4 beats: every output returns to 0 and the FSM to IDLE. A fresh all-1s cfg = 2 frame then yields exactly 1 per channel.

Source files
------------

// File: rtl/gap_pool_unit.sv
// Global pooling engine: reduces each channel of a streamed multi-lane feature map
// to a single round-half-to-even average or maximum, emitted one channel per result.
module gap_pool_unit #(
  parameter int DATA_W         = 8,
  parameter int CH             = 4,
  parameter int LANES          = 4,
  parameter int LOG2_BEATS_MAX = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   cfg_mode,
  input  logic [$clog2(LOG2_BEATS_MAX+1)-1:0]    cfg_log2_beats,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CH*LANES*DATA_W-1:0]             in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DATA_W-1:0]                      out_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
  output logic                                   out_last,
  output logic                                   busy
);

  localparam int SH_L   = $clog2(LANES);
  localparam int ACC_W  = DATA_W + SH_L + LOG2_BEATS_MAX;
  localparam int CFG_W  = $clog2(LOG2_BEATS_MAX + 1);
  localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int BEAT_W = (LOG2_BEATS_MAX > 0) ? LOG2_BEATS_MAX : 1;
  localparam logic [CFG_W-1:0] CFG_MAX = CFG_W'(LOG2_BEATS_MAX);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_POP} state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc [CH];
  logic [BEAT_W-1:0]  r_beat;
  logic [CH_W-1:0]    r_idx;
  logic               r_mode;
  logic [CFG_W-1:0]   r_cfg;

  logic [CFG_W-1:0]   w_cfg_clamp;
  logic               w_beat_last;
  logic [ACC_W-1:0]   w_sum     [CH];
  logic [DATA_W-1:0]  w_mx      [CH];
  logic [ACC_W-1:0]   w_acc_nxt [CH];
  logic [DATA_W-1:0]  w_lane;
  logic [ACC_W-1:0]   w_acc_sel, w_q, w_mask, w_r, w_half, w_avg;
  logic [7:0]         w_s;
  logic               w_up;

  assign w_cfg_clamp = (cfg_log2_beats > CFG_MAX) ? CFG_MAX : cfg_log2_beats;
  assign w_beat_last = (r_beat == BEAT_W'((1 << r_cfg) - 1));

  always_comb begin
    w_lane = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      w_sum[c] = '0;
      w_mx[c]  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        w_lane   = in_data[(c*LANES + l)*DATA_W +: DATA_W];
        w_sum[c] = w_sum[c] + ACC_W'(w_lane);
        if (w_lane > w_mx[c]) w_mx[c] = w_lane;
      end
      if (r_mode)
        w_acc_nxt[c] = (ACC_W'(w_mx[c]) > r_acc[c]) ? ACC_W'(w_mx[c]) : r_acc[c];
      else
        w_acc_nxt[c] = r_acc[c] + w_sum[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      for (int unsigned c = 0; c < CH; c++) r_acc[c] <= '0;
      r_beat  <= '0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_cfg   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_mode <= cfg_mode;
          r_cfg  <= w_cfg_clamp;
          r_beat <= '0;
          for (int unsigned c = 0; c < CH; c++) r_acc[c] <= '0;
        end
        S_ACC: if (in_valid) begin
          for (int unsigned c = 0; c < CH; c++) r_acc[c] <= w_acc_nxt[c];
          r_beat <= r_beat + 1'b1;
          if (w_beat_last) r_idx <= '0;
        end
        S_POP: if (out_ready) r_idx <= (r_idx == LAST_CH) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_ACC;
      S_ACC:   if (in_valid && w_beat_last) w_state_nxt = S_POP;
      S_POP:   if (out_ready && (r_idx == LAST_CH)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Divide by 2^s with ties to even; s == 0 degenerates to a pass-through since w_up stays 0.
  always_comb begin
    w_acc_sel = r_acc[r_idx];
    w_s       = 8'(SH_L) + 8'(r_cfg);
    w_q       = w_acc_sel >> w_s;
    w_mask    = (ACC_W'(1) << w_s) - ACC_W'(1);
    w_r       = w_acc_sel & w_mask;
    w_half    = (w_s == 8'd0) ? '0 : (ACC_W'(1) << (w_s - 8'd1));
    w_up      = (w_s != 8'd0) && ((w_r > w_half) || ((w_r == w_half) && w_q[0]));
    w_avg     = w_q + ACC_W'(w_up);
  end

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = (r_state == S_POP);
  assign busy      = (r_state != S_IDLE);
  assign out_ch    = r_idx;
  assign out_last  = out_valid && (r_idx == LAST_CH);
  assign out_data  = !out_valid ? '0 : (r_mode ? w_acc_sel[DATA_W-1:0] : w_avg[DATA_W-1:0]);

endmodule

// File: tb/tb_gap_pool_unit.sv
// Directed bench for gap_pool_unit: hand-computed averages/maxima, handshake gaps,
// output back-pressure, ignored starts and mid-frame reset.
module tb_gap_pool_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         cfg_mode;
  logic [2:0]   cfg_log2_beats;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [1:0]   out_ch;
  logic         out_last;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gap_pool_unit #(.DATA_W(8), .CH(4), .LANES(4), .LOG2_BEATS_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
    .cfg_log2_beats(cfg_log2_beats), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic mode, input logic [2:0] cfg);
    start = 1'b1; cfg_mode = mode; cfg_log2_beats = cfg;
    tick();
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic beat(input logic [127:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic drain(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("%s_valid%0d", tag, c), out_valid, 1);
      chk($sformatf("%s_ch%0d", tag, c), out_ch, c);
      chk($sformatf("%s_data%0d", tag, c), out_data, e[c]);
      chk($sformatf("%s_last%0d", tag, c), out_last, (c == 3) ? 1 : 0);
      tick();
    end
    out_ready = 1'b0;
    chk($sformatf("%s_idle", tag), busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_log2_beats = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Average, one beat: ties to even both ways, max value, plain round-up
    start_frame(1'b0, 3'd0);
    beat({32'h03000000, 32'hFFFFFFFF, 32'h05030303, 32'h04030201});
    drain("avg1", 8'd2, 8'd4, 8'd255, 8'd1);
    tick();

    // Average, 4 beats (divide by 16)
    start_frame(1'b0, 3'd2);
    beat({32'h00000000, 32'h00000018, 32'h00000008, 32'h01010101});
    beat({32'h00000000, 32'h00000000, 32'h00000000, 32'h01010101});
    beat({32'h00000000, 32'h00000000, 32'h00000000, 32'h01010101});
    chk("avg4_not_yet", out_valid, 0);
    beat({32'h00000000, 32'h00000000, 32'h00000000, 32'h01010101});
    drain("avg4", 8'd1, 8'd0, 8'd2, 8'd0);
    tick();

    // Max, 2 beats; a valid beat coinciding with start must not be taken
    in_valid = 1'b1; in_data = {128{1'b1}};
    start_frame(1'b1, 3'd1);
    in_valid = 1'b0;
    beat({32'hFFFFFFFF, 32'h03030303, 32'h00000000, 32'h07020905});
    beat({32'h00000000, 32'h000000C8, 32'h00000000, 32'h000C0101});
    drain("max2", 8'd12, 8'd0, 8'd200, 8'd255);
    tick();

    // Gapped in_valid: only handshakes count; garbage on idle cycles
    start_frame(1'b0, 3'd2);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i == 1 || i == 3) ? 1'b0 : 1'b1;
      in_data  = (i == 1 || i == 3) ? {128{1'b1}} : {16{8'h02}};
      tick();
      if (i < 5) chk($sformatf("gap_valid_low%0d", i), out_valid, 0);
    end
    in_valid = 1'b0; in_data = '0;
    drain("gap", 8'd2, 8'd2, 8'd2, 8'd2);
    tick();

    // Back-pressure at channel 1 with start held throughout POP
    start_frame(1'b1, 3'd0);
    beat({32'h00000000, 32'h80000001, 32'h00000063, 32'h0A141E28});
    start = 1'b1;
    out_ready = 1'b1;
    chk("bp_d0", out_data, 8'h28);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), out_valid, 1);
      chk($sformatf("bp_hold_ch%0d", i), out_ch, 1);
      chk($sformatf("bp_hold_data%0d", i), out_data, 8'h63);
      chk($sformatf("bp_hold_last%0d", i), out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_ch1_after", out_ch, 1);
    tick();
    chk("bp_d2", out_data, 8'h80);
    tick();
    chk("bp_d3", out_data, 8'h00);
    chk("bp_last3", out_last, 1);
    tick();
    chk("bp_start_ignored", busy, 0);
    chk("bp_in_ready_idle", in_ready, 0);
    start = 1'b0; out_ready = 1'b0;
    tick();

    // cfg above maximum clamps to 16 beats
    start_frame(1'b0, 3'd7);
    for (int i = 0; i < 15; i++) beat({16{8'h05}});
    chk("clamp_not_yet", out_valid, 0);
    chk("clamp_busy", busy, 1);
    beat({16{8'h05}});
    drain("clamp", 8'd5, 8'd5, 8'd5, 8'd5);
    tick();

    // Reset mid-frame, then a clean frame
    start_frame(1'b0, 3'd2);
    beat({16{8'h09}});
    beat({16{8'h09}});
    rst_n = 1'b0; in_valid = 1'b1; in_data = {16{8'h09}};
    tick();
    rst_n = 1'b1; in_valid = 1'b0; in_data = '0;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_out_ch", out_ch, 0);
    chk("mrst_out_last", out_last, 0);
    chk("mrst_busy", busy, 0);
    start_frame(1'b0, 3'd2);
    for (int i = 0; i < 4; i++) beat({16{8'h01}});
    drain("post_rst", 8'd1, 8'd1, 8'd1, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
